// File: rtl/rv32i_sequencer_pkg.sv
// Shared state encodings, trap causes and RV32I major opcodes for the sequencer.
// Pure declarations; no logic.
package rv32i_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_t;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_BUS     = 2'd1;
  localparam logic [1:0] CAUSE_ECALL   = 2'd2;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  // SYSTEM is deliberately absent: it traps as an environment call instead.
  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
      OPCODE_LOAD, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_OP, OPCODE_FENCE:
        is_legal = 1'b1;
      default:
        is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_sequencer_wait_timer.sv
// Ack wait counter: cleared outside the wait states, counts unacknowledged cycles,
// saturates at TIMEOUT and flags expired combinationally from the count.
module rv32i_sequencer_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/rv32i_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with req/ack memory ports,
// halt at instruction boundaries, bus-timeout/illegal/ecall traps and an instret counter.
module rv32i_sequencer
  import rv32i_sequencer_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt,
  input  logic [6:0]           opcode,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 reg_write,
  output logic                 inst_req,
  input  logic                 inst_ack,
  output logic                 ir_load,
  output logic                 data_req,
  input  logic                 data_ack,
  output logic                 pc_update,
  output logic                 rd_we,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] instret
);

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       wait_clear, wait_enable, wait_expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_ILLEGAL;
      instret <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == ST_WRITEBACK) begin
        instret <= instret + CNT_WIDTH'(1);
      end
    end
  end

  // An ack on the expiry cycle takes priority over the bus trap.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    inst_req  = 1'b0;
    ir_load   = 1'b0;
    data_req  = 1'b0;
    pc_update = 1'b0;
    rd_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!halt) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        inst_req = !reset;
        ir_load  = !reset && inst_ack;
        if (inst_ack) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      ST_DECODE: begin
        if (opcode == OPCODE_SYSTEM) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ECALL;
        end else if (is_legal(opcode)) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXECUTE: begin
        state_d = (mem_read || mem_write) ? ST_MEM : ST_WRITEBACK;
      end
      ST_MEM: begin
        data_req = !reset;
        if (data_ack) begin
          state_d = ST_WRITEBACK;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      ST_WRITEBACK: begin
        pc_update = !reset;
        rd_we     = !reset && reg_write;
        state_d   = halt ? ST_IDLE : ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counter idles at zero outside FETCH/MEM, so every entry starts a fresh wait.
  assign wait_clear  = (state_q != ST_FETCH) && (state_q != ST_MEM);
  assign wait_enable = ((state_q == ST_FETCH) && !inst_ack) ||
                       ((state_q == ST_MEM) && !data_ack);

  rv32i_sequencer_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (wait_clear),
    .enable (wait_enable),
    .expired(wait_expired)
  );

  assign state      = state_q;
  assign halted     = (state_q == ST_IDLE);
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_rv32i_sequencer.sv
// Directed bench: a queue of per-cycle stimulus plus expected outputs, popped and
// checked one cycle at a time against the sequencer built with TIMEOUT=4.
module tb_rv32i_sequencer;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_FEN = 7'b0001111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  // ins = {reset, halt, inst_ack, data_ack}; ctl = {mem_read, mem_write, reg_write}
  localparam logic [3:0] R = 4'b1000, H = 4'b0100, IA = 4'b0010, DA = 4'b0001, NO = 4'b0000;
  // outs = {inst_req, data_req, ir_load, pc_update, rd_we}
  localparam logic [4:0] Z = 5'b00000, FQ = 5'b10000, FL = 5'b10100, MQ = 5'b01000;

  typedef struct {
    string       tag;
    logic [3:0]  ins;
    logic [6:0]  op;
    logic [2:0]  ctl;
    logic [2:0]  st;
    logic [4:0]  outs;
    logic [1:0]  cause;
    logic [31:0] ret;
  } step_t;

  logic        clk = 1'b0;
  logic        reset, halt, mem_read, mem_write, reg_write, inst_ack, data_ack;
  logic [6:0]  opcode;
  logic        inst_req, ir_load, data_req, pc_update, rd_we, halted, trap;
  logic [2:0]  state;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  step_t       q[$];
  logic [1:0]  cur_cause;
  logic [31:0] cur_ret;
  int          passes = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  rv32i_sequencer #(.TIMEOUT(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .halt(halt), .opcode(opcode),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .inst_req(inst_req), .inst_ack(inst_ack), .ir_load(ir_load),
    .data_req(data_req), .data_ack(data_ack), .pc_update(pc_update),
    .rd_we(rd_we), .state(state), .halted(halted), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  task automatic add(input string tag, input logic [3:0] ins, input logic [6:0] op,
                     input logic [2:0] ctl, input logic [2:0] st, input logic [4:0] outs);
    step_t s;
    s.tag = tag; s.ins = ins; s.op = op; s.ctl = ctl; s.st = st; s.outs = outs;
    s.cause = cur_cause; s.ret = cur_ret;
    q.push_back(s);
  endtask

  task automatic run_queue();
    step_t s;
    logic [11:0] obs, exp;
    while (q.size() > 0) begin
      s = q.pop_front();
      {reset, halt, inst_ack, data_ack} = s.ins;
      {mem_read, mem_write, reg_write}  = s.ctl;
      opcode = s.op;
      #1;
      obs = {state, inst_req, data_req, ir_load, pc_update, rd_we, halted, trap, trap_cause};
      exp = {s.st, s.outs, (s.st == 3'd0), (s.st == 3'd6), s.cause};
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s ctl: observed %h expected %h", s.tag, obs, exp);
      total++;
      assert (instret === s.ret) passes++;
      else $error("FAIL %s instret: observed %0d expected %0d", s.tag, instret, s.ret);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; halt = 1'b1; inst_ack = 1'b0; data_ack = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; opcode = 7'd0;
    cur_cause = 2'd0; cur_ret = 0;
    repeat (2) @(negedge clk);

    add("reset", R, 0, 0, 0, Z);
    add("idle", NO, 0, 0, 0, Z);
    // OP-IMM, zero-wait: 4 cycles
    add("opimm_f", IA, 0, 0, 1, FL);
    add("opimm_d", NO, OP_IMM, 0, 2, Z);
    add("opimm_e", NO, 0, 3'b001, 3, Z);
    add("opimm_w", NO, 0, 3'b001, 5, 5'b00011); cur_ret = 1;
    // LOAD, data_ack three cycles after data_req rises
    add("load_f", IA, 0, 0, 1, FL);
    add("load_d", NO, OP_LD, 0, 2, Z);
    add("load_e", NO, 0, 3'b101, 3, Z);
    for (int i = 0; i < 3; i++) add("load_mwait", NO, 0, 3'b101, 4, MQ);
    add("load_mack", DA, 0, 3'b101, 4, MQ);
    add("load_w", NO, 0, 3'b101, 5, 5'b00011); cur_ret = 2;
    // STORE with halt raised during MEM
    add("st_f", IA, 0, 0, 1, FL);
    add("st_d", NO, OP_ST, 0, 2, Z);
    add("st_e", NO, 0, 3'b010, 3, Z);
    add("st_mwait", H, 0, 3'b010, 4, MQ);
    add("st_mack", H | DA, 0, 3'b010, 4, MQ);
    add("st_w", H, 0, 3'b010, 5, 5'b00010); cur_ret = 3;
    add("halt_idle", H, 0, 0, 0, Z);
    add("resume", NO, 0, 0, 0, Z);
    // fetch ack exactly at count 4, then FENCE as a no-op
    for (int i = 0; i < 4; i++) add("late_fwait", NO, 0, 0, 1, FQ);
    add("late_fack", IA, 0, 0, 1, FL);
    add("fence_d", NO, OP_FEN, 0, 2, Z);
    add("fence_e", NO, 0, 0, 3, Z);
    add("fence_w", NO, 0, 0, 5, 5'b00010); cur_ret = 4;
    // SYSTEM -> ecall trap
    add("sys_f", IA, 0, 0, 1, FL);
    add("sys_d", NO, OP_SYS, 0, 2, Z); cur_cause = 2;
    add("sys_trap", IA | DA, 0, 3'b111, 6, Z);
    add("sys_hold", NO, 0, 3'b001, 6, Z);
    add("sys_rst", R, 0, 0, 6, Z); cur_cause = 0; cur_ret = 0;
    // illegal opcode
    add("ill_idle", NO, 0, 0, 0, Z);
    add("ill_f", IA, 0, 0, 1, FL);
    add("ill_d", NO, OP_BAD, 0, 2, Z);
    add("ill_trap", IA | DA, 0, 3'b111, 6, Z);
    add("ill_rst", R, 0, 0, 6, Z);
    // fetch timeout: five unacknowledged request cycles
    add("to_idle", NO, 0, 0, 0, Z);
    for (int i = 0; i < 5; i++) add("to_fwait", NO, 0, 0, 1, FQ);
    cur_cause = 1;
    add("to_trap", IA | DA, 0, 3'b001, 6, Z);
    add("to_hold", IA | DA, 0, 3'b001, 6, Z);
    add("to_rst", R, 0, 0, 6, Z); cur_cause = 0;
    // reset in MEM together with data_ack
    add("rm_idle", NO, 0, 0, 0, Z);
    add("rm_f", IA, 0, 0, 1, FL);
    add("rm_d", NO, OP_LD, 0, 2, Z);
    add("rm_e", NO, 0, 3'b101, 3, Z);
    add("rm_mwait", NO, 0, 3'b101, 4, MQ);
    add("rm_rst_ack", R | DA, 0, 3'b101, 4, Z);
    add("rm_after", H | DA, 0, 3'b101, 0, Z);
    add("rm_idle2", NO, 0, 0, 0, Z);
    add("rm_fetch", NO, 0, 0, 1, FQ);

    run_queue();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/rv32i_sequencer.md
# rv32i_sequencer

Multi-cycle control sequencer for the RV32I core. It drives the fetch/decode/execute/memory/writeback cycle with req/ack handshakes to instruction and data memory, so memories with any number of wait states are supported. It also provides a halt/resume mode, bus-timeout and illegal-instruction traps, and a retired-instruction counter. It sits between the memory ports and the datapath (decode, control unit, program counter, register file), and gates the latching of the instruction register, the PC update and register writeback.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum wait cycles for a memory ack before a bus trap. Legal range is 1..65535; the counter width is clog2(TIMEOUT+1).
- `CNT_WIDTH`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `halt`  in  1  request to stop at the next instruction boundary.
- `opcode`  in  7  opcode field from decode, taken from the latched instruction.
- `mem_read`  in  1  control unit: instruction is a load.
- `mem_write`  in  1  control unit: instruction is a store.
- `reg_write`  in  1  control unit: instruction writes rd.
- `inst_req`  out  1  instruction fetch request.
- `inst_ack`  in  1  instruction memory data valid.
- `ir_load`  out  1  one-cycle pulse that latches `instruction_data` into the instruction register.
- `data_req`  out  1  data memory request; the store byte-enables are qualified by it.
- `data_ack`  in  1  data memory complete (read data valid or write done).
- `pc_update`  out  1  one-cycle pulse; the PC takes `pc_next`.
- `rd_we`  out  1  register-file write enable.
- `state`  out  3  current state, for debug.
- `halted`  out  1  sequencer is in IDLE.
- `trap`  out  1  sticky trap flag.
- `trap_cause`  out  2  trap cause code: 0 illegal, 1 bus timeout, 2 environment call.
- `instret`  out  CNT_WIDTH  count of retired instructions.

## Operation
- States are IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK and TRAP.
- IDLE:
  - Entered on reset.
  - Moves to FETCH on the first cycle that `halt` is 0.
  - `halted`=1 while in this state.
- FETCH:
  - `inst_req`=1.
  - An `inst_ack` sampled at a clock edge gives `ir_load`=1 in that same cycle and moves to DECODE.
- DECODE (one cycle):
  - A legal opcode moves to EXECUTE. The legal set is LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP and FENCE.
  - SYSTEM (1110011) moves to TRAP with cause 2.
  - Any other opcode moves to TRAP with cause 0.
- EXECUTE (one cycle): if `mem_read` or `mem_write` is set, go to MEM; otherwise go to WRITEBACK.
- MEM:
  - `data_req`=1 until `data_ack`, then WRITEBACK.
  - Load data must be valid in the `data_ack` cycle; the register-file source is captured by the datapath at WRITEBACK.
- WRITEBACK (one cycle):
  - `rd_we`=`reg_write`, `pc_update`=1, `instret` increments (wrapping at 2^CNT_WIDTH).
  - Next state is IDLE if `halt`=1, otherwise FETCH.
- TRAP:
  - `trap`=1, and `trap_cause` is held.
  - `ir_load`, `pc_update`, `rd_we`, `inst_req` and `data_req` are all 0.
  - Only `reset` exits this state.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments every cycle the request is unacknowledged. If the counter reaches `TIMEOUT` with no ack in that cycle, go to TRAP with cause 1. An ack in the same cycle the counter reaches `TIMEOUT` wins, and no trap is taken.
- Acks arriving while the matching request is 0 are ignored.
- FENCE executes as a no-op: it passes through EXECUTE to WRITEBACK.

## Timing
- Reset values:
  - State IDLE (`state`=0), `halted`=1.
  - `trap`=0, `trap_cause`=0, `instret`=0.
  - All request, strobe and enable outputs 0.
- `inst_req`, `data_req`, `ir_load`, `pc_update` and `rd_we` are decoded combinationally from the state register and the same-cycle ack/control inputs. There are no registered-output delays.
- Cycles per instruction with zero-wait memories (ack in the first request cycle):
  - ALU, branch and jump: 4 cycles.
  - Load and store: 5 cycles.
  - Each wait cycle adds 1.
- `halt` is sampled only in WRITEBACK and in IDLE. Asserting it mid-instruction completes the current instruction first.
- Reset in any state, including mid-handshake, forces IDLE on the next edge. Requests drop in that cycle and any in-flight ack is discarded.
- Reset asserted together with an ack: reset wins.

## Structure
- The shared defines file holds:
  - state encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, TRAP=6;
  - trap cause codes;
  - the existing `OPCODE_*` constants, which are reused for legality decode.
- One sub-module, `wait_timer`: a clear/enable/expired counter parameterised by `TIMEOUT`, shared by FETCH and MEM.
- `instret` and the state register are inline.

## Test plan
- Reset, then `halt`=0 and OP-IMM (0010011) with `inst_ack` in the first cycle, `reg_write`=1 → `state` 0→1→2→3→5→1, with `rd_we` and `pc_update` each high one cycle and `instret`=1.
- LOAD with a `data_ack` 3 cycles after `data_req` rises → `data_req` high 4 cycles, WRITEBACK in the next cycle, total 8 cycles, `rd_we`=1.
- `TIMEOUT`=4 and no `inst_ack` → `inst_req` high 5 cycles, then `trap`=1, `trap_cause`=1, requests 0 until reset; also an ack exactly at count 4 → no trap.
- Opcode 0000000 → TRAP with cause 0; opcode 1110011 → cause 2; `rd_we` and `pc_update` never assert.
- `halt` raised during MEM of a STORE → store completes, `pc_update` pulses, IDLE with `halted`=1; drop `halt` → FETCH on the next cycle.
- `reset` asserted while in MEM with `data_ack`=1 in the same cycle → IDLE, `instret` unchanged at 0, no `rd_we`.
